// File: rtl/mse_port_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mse_port_sequencer
// Purpose  : Grid-bus I/O controller for ten MSE ports with a prescaled
//            pattern counter that can override selected ports.
// Revision : 1.0  initial release
// ============================================================================
module mse_port_sequencer #(
    parameter int PORT_W      = 8,
    parameter int PRESC_W     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        address,
    inout  wire  [15:0]       data,
    input  logic              wr,
    input  logic              rd,
    inout  wire  [PORT_W-1:0] port0,
    inout  wire  [PORT_W-1:0] port1,
    inout  wire  [PORT_W-1:0] port2,
    inout  wire  [PORT_W-1:0] port3,
    inout  wire  [PORT_W-1:0] port4,
    inout  wire  [PORT_W-1:0] port5,
    inout  wire  [PORT_W-1:0] port6,
    inout  wire  [PORT_W-1:0] port7,
    inout  wire  [PORT_W-1:0] port8,
    inout  wire  [PORT_W-1:0] port9
);

    localparam int         c_NPORT     = 10;
    localparam logic [7:0] c_ADDR_CTRL = 8'h30;
    localparam logic [7:0] c_ADDR_PRSC = 8'h31;
    localparam logic [7:0] c_ADDR_MASK = 8'h32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_wr_q;
    logic [PORT_W-1:0]    r_out  [c_NPORT];
    logic [PORT_W-1:0]    r_dir  [c_NPORT];
    logic [c_NPORT-1:0]   r_mask;
    logic [PRESC_W-1:0]   r_presc;
    logic [1:0]           r_ctrl;
    logic [PORT_W-1:0]    r_cnt;
    logic [PRESC_W-1:0]   r_pcnt;
    logic [PORT_W-1:0]    r_sync [SYNC_STAGES][c_NPORT];

    logic                 w_wr_fire;
    logic                 w_ctrl_wr;
    logic [3:0]           w_idx;
    logic                 w_idx_ok;
    logic                 w_ovr;
    logic [15:0]          w_rdata;
    logic [15:0]          w_status;
    logic [PORT_W-1:0]    w_drv  [c_NPORT];
    logic [PORT_W-1:0]    w_pad  [c_NPORT];

    // A held strobe writes once: only the cycle where wr rises is a write.
    assign w_wr_fire = wr & ~r_wr_q;
    assign w_ctrl_wr = w_wr_fire && (address == c_ADDR_CTRL);
    assign w_idx     = address[3:0];
    assign w_idx_ok  = (address[3:0] < 4'd10);
    assign w_ovr     = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_q  <= 1'b0;
            r_mask  <= '0;
            r_presc <= '0;
            r_ctrl  <= '0;
            for (int p = 0; p < c_NPORT; p++) begin
                r_out[p] <= '0;
                r_dir[p] <= '0;
            end
        end else begin
            r_wr_q <= wr;
            if (w_wr_fire) begin
                if (address[7:4] == 4'h0 && w_idx_ok) begin
                    r_out[w_idx] <= data[PORT_W-1:0];
                end
                if (address[7:4] == 4'h1 && w_idx_ok) begin
                    r_dir[w_idx] <= data[PORT_W-1:0];
                end
                if (address == c_ADDR_CTRL) begin
                    r_ctrl <= data[1:0];
                end
                if (address == c_ADDR_PRSC) begin
                    r_presc <= data[PRESC_W-1:0];
                end
                if (address == c_ADDR_MASK) begin
                    r_mask <= data[c_NPORT-1:0];
                end
            end
        end
    end

    // Sequencer: a CTRL write always takes priority over a tick in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pcnt  <= '0;
        end else if (w_ctrl_wr) begin
            r_state <= data[0] ? ST_RUN : ST_IDLE;
            r_cnt   <= '0;
            r_pcnt  <= '0;
        end else if (r_state == ST_RUN) begin
            if (r_pcnt >= r_presc) begin
                r_pcnt <= '0;
                if (r_ctrl[1] && (r_cnt == '1)) begin
                    r_state <= ST_DONE;
                end else begin
                    r_cnt <= r_cnt + PORT_W'(1);
                end
            end else begin
                r_pcnt <= r_pcnt + PRESC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                for (int p = 0; p < c_NPORT; p++) begin
                    r_sync[s][p] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < c_NPORT; p++) begin
                r_sync[0][p] <= w_pad[p];
                for (int s = 1; s < SYNC_STAGES; s++) begin
                    r_sync[s][p] <= r_sync[s-1][p];
                end
            end
        end
    end

    assign w_status = 16'({r_cnt, 6'd0, (r_state == ST_DONE), (r_state == ST_RUN)});

    always_comb begin
        w_rdata = '0;
        case (address[7:4])
            4'h0: if (w_idx_ok) w_rdata = 16'(r_out[w_idx]);
            4'h1: if (w_idx_ok) w_rdata = 16'(r_dir[w_idx]);
            4'h2: if (w_idx_ok) w_rdata = 16'(r_sync[SYNC_STAGES-1][w_idx]);
            4'h3: begin
                case (address[3:0])
                    4'h0:    w_rdata = {14'd0, r_ctrl};
                    4'h1:    w_rdata = 16'(r_presc);
                    4'h2:    w_rdata = 16'(r_mask);
                    4'h3:    w_rdata = w_status;
                    default: w_rdata = '0;
                endcase
            end
            default: w_rdata = '0;
        endcase
    end

    assign data = rd ? w_rdata : 16'bz;

    always_comb begin
        for (int p = 0; p < c_NPORT; p++) begin
            w_drv[p] = (r_mask[p] && w_ovr) ? r_cnt : r_out[p];
        end
    end

    assign w_pad[0] = port0;
    assign w_pad[1] = port1;
    assign w_pad[2] = port2;
    assign w_pad[3] = port3;
    assign w_pad[4] = port4;
    assign w_pad[5] = port5;
    assign w_pad[6] = port6;
    assign w_pad[7] = port7;
    assign w_pad[8] = port8;
    assign w_pad[9] = port9;

    for (genvar b = 0; b < PORT_W; b++) begin : g_bit
        assign port0[b] = r_dir[0][b] ? w_drv[0][b] : 1'bz;
        assign port1[b] = r_dir[1][b] ? w_drv[1][b] : 1'bz;
        assign port2[b] = r_dir[2][b] ? w_drv[2][b] : 1'bz;
        assign port3[b] = r_dir[3][b] ? w_drv[3][b] : 1'bz;
        assign port4[b] = r_dir[4][b] ? w_drv[4][b] : 1'bz;
        assign port5[b] = r_dir[5][b] ? w_drv[5][b] : 1'bz;
        assign port6[b] = r_dir[6][b] ? w_drv[6][b] : 1'bz;
        assign port7[b] = r_dir[7][b] ? w_drv[7][b] : 1'bz;
        assign port8[b] = r_dir[8][b] ? w_drv[8][b] : 1'bz;
        assign port9[b] = r_dir[9][b] ? w_drv[9][b] : 1'bz;
    end

endmodule
`default_nettype wire

// File: tb/tb_mse_port_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mse_port_sequencer
// Purpose  : Scoreboard bench for mse_port_sequencer against a timing-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mse_port_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  address = '0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [15:0] drv_data = '0;
    logic        drv_oe = 1'b0;
    wire  [15:0] data;
    wire  [7:0]  p0, p1, p2, p3, p4, p5, p6, p7, p8, p9;

    logic [7:0]  ext_val [10];
    logic [7:0]  ext_oe  [10];
    logic [7:0]  pv      [10];

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        pchk = 1'b0;
    int          pidx = 0;
    logic [15:0] exp_q [$];
    string       nm_q  [$];
    logic [15:0] mon_act, mon_exp;
    string       mon_nm;

    // reference model state
    logic [7:0]  m_out [10];
    logic [7:0]  m_dir [10];
    logic [9:0]  m_mask;
    logic [15:0] m_presc;
    logic [1:0]  m_ctrl;
    int          m_start;

    mse_port_sequencer dut (
        .clk(clk), .reset_n(reset_n), .address(address), .data(data),
        .wr(wr), .rd(rd),
        .port0(p0), .port1(p1), .port2(p2), .port3(p3), .port4(p4),
        .port5(p5), .port6(p6), .port7(p7), .port8(p8), .port9(p9)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign data = drv_oe ? drv_data : 16'bz;

    for (genvar b = 0; b < 8; b++) begin : g_ext
        assign p0[b] = ext_oe[0][b] ? ext_val[0][b] : 1'bz;
        assign p1[b] = ext_oe[1][b] ? ext_val[1][b] : 1'bz;
        assign p2[b] = ext_oe[2][b] ? ext_val[2][b] : 1'bz;
        assign p3[b] = ext_oe[3][b] ? ext_val[3][b] : 1'bz;
        assign p4[b] = ext_oe[4][b] ? ext_val[4][b] : 1'bz;
        assign p5[b] = ext_oe[5][b] ? ext_val[5][b] : 1'bz;
        assign p6[b] = ext_oe[6][b] ? ext_val[6][b] : 1'bz;
        assign p7[b] = ext_oe[7][b] ? ext_val[7][b] : 1'bz;
        assign p8[b] = ext_oe[8][b] ? ext_val[8][b] : 1'bz;
        assign p9[b] = ext_oe[9][b] ? ext_val[9][b] : 1'bz;
    end

    assign pv[0] = p0; assign pv[1] = p1; assign pv[2] = p2; assign pv[3] = p3;
    assign pv[4] = p4; assign pv[5] = p5; assign pv[6] = p6; assign pv[7] = p7;
    assign pv[8] = p8; assign pv[9] = p9;

    // ---------------- reference model ----------------
    function automatic int m_ticks();
        return (cyc - m_start) / (int'(m_presc) + 1);
    endfunction

    function automatic int m_state();   // 0 idle, 1 run, 2 done
        if (!m_ctrl[0]) return 0;
        if (m_ctrl[1] && m_ticks() >= 256) return 2;
        return 1;
    endfunction

    function automatic logic [7:0] m_cnt();
        int t;
        if (!m_ctrl[0]) return 8'h00;
        t = m_ticks();
        if (m_ctrl[1] && t >= 255) return 8'hFF;
        return 8'(t % 256);
    endfunction

    function automatic logic [7:0] m_pad(int i);
        logic [7:0] v;
        v = (m_mask[i] && m_state() != 0) ? m_cnt() : m_out[i];
        return (m_dir[i] & v) | (~m_dir[i] & ext_val[i]);
    endfunction

    function automatic logic [15:0] m_read(logic [7:0] a);
        int i;
        int st;
        i = int'(a[3:0]);
        st = m_state();
        if (a[7:4] == 4'h0 && i < 10) return {8'h00, m_out[i]};
        if (a[7:4] == 4'h1 && i < 10) return {8'h00, m_dir[i]};
        if (a[7:4] == 4'h2 && i < 10) return {8'h00, m_pad(i)};
        if (a == 8'h30) return {14'd0, m_ctrl};
        if (a == 8'h31) return m_presc;
        if (a == 8'h32) return {6'd0, m_mask};
        if (a == 8'h33) return {m_cnt(), 6'd0, (st == 2), (st == 1)};
        return 16'h0000;
    endfunction

    function automatic void model_write(logic [7:0] a, logic [15:0] v);
        int i;
        i = int'(a[3:0]);
        if (a[7:4] == 4'h0 && i < 10) m_out[i] = v[7:0];
        else if (a[7:4] == 4'h1 && i < 10) begin
            m_dir[i]  = v[7:0];
            ext_oe[i] = ~v[7:0];
        end
        else if (a == 8'h30) begin
            m_ctrl  = v[1:0];
            m_start = cyc;
        end
        else if (a == 8'h31) m_presc = v;
        else if (a == 8'h32) m_mask = v[9:0];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 10; i++) begin
            m_out[i]  = 8'h00;
            m_dir[i]  = 8'h00;
            ext_oe[i] = 8'hFF;
        end
        m_mask  = '0;
        m_presc = '0;
        m_ctrl  = '0;
        m_start = 0;
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic bus_write(input logic [7:0] a, input logic [15:0] v, input int hold);
        @(posedge clk); #1;
        address = a; drv_data = v; drv_oe = 1'b1; wr = 1'b1;
        @(posedge clk); #1;
        model_write(a, v);
        drv_data = 16'($urandom);   // later strobe cycles must not write again
        for (int h = 1; h < hold; h++) begin
            @(posedge clk); #1;
        end
        wr = 1'b0; drv_oe = 1'b0;
    endtask

    task automatic chk_read(input logic [7:0] a, input string nm);
        @(posedge clk); #1;
        address = a; rd = 1'b1;
        exp_q.push_back(m_read(a));
        nm_q.push_back(nm);
        @(negedge clk); #1;
        rd = 1'b0;
    endtask

    task automatic chk_pad(input int i, input string nm);
        @(posedge clk); #1;
        pidx = i; pchk = 1'b1;
        exp_q.push_back({8'h00, m_pad(i)});
        nm_q.push_back(nm);
        @(negedge clk); #1;
        pchk = 1'b0;
    endtask

    task automatic wait_k(input int k);
        while (cyc - m_start < k - 1) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rd || pchk) begin
            mon_act = rd ? data : {8'h00, pv[pidx]};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_underflow: got %h want <entry>", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_nm  = nm_q.pop_front();
                if (mon_act !== mon_exp) begin
                    bad++;
                    $display("FAIL %s: got %h want %h (t=%0t)", mon_nm, mon_act, mon_exp, $time);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 10; i++) ext_val[i] = 8'h00;
        do_reset();
        repeat (3) @(negedge clk);

        // reset state: every register reads zero, pads undriven by the DUT
        for (int a = 0; a <= 8'h33; a++) chk_read(8'(a), $sformatf("reset_rd_%02h", a));
        for (int i = 0; i < 10; i++) ext_val[i] = 8'($urandom);
        for (int i = 0; i < 10; i++) chk_pad(i, $sformatf("reset_pad%0d", i));

        // single write per strobe; readback through synchroniser
        bus_write(8'h10, 16'h00FF, 1);
        bus_write(8'h00, 16'h00A5, 5);
        chk_pad(0, "port0_out");
        chk_read(8'h00, "out0_once");
        repeat (2) @(posedge clk);
        chk_read(8'h20, "in0_readback");

        // pattern counter, PRESC=3, through the wrap
        bus_write(8'h03, 16'h0096, 2);
        bus_write(8'h13, 16'h00FF, 1);
        bus_write(8'h32, 16'h0008, 1);
        bus_write(8'h31, 16'h0003, 1);
        bus_write(8'h30, 16'h0001, 1);
        while (cyc - m_start < 1000) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            chk_pad(3, "cnt_port3");
            chk_read(8'h33, "status_run");
        end
        wait_k(1023); chk_pad(3, "pre_wrap");
        chk_pad(3, "post_wrap");
        chk_read(8'h33, "status_wrap");

        // one-shot with PRESC=0
        bus_write(8'h31, 16'h0000, 1);
        bus_write(8'h30, 16'h0003, 1);
        chk_pad(3, "os_first");
        wait_k(255); chk_pad(3, "os_last_run");
        chk_read(8'h33, "os_done_status");
        repeat (20) @(posedge clk);
        chk_read(8'h33, "os_done_hold");
        chk_pad(3, "os_port3_hold");
        bus_write(8'h30, 16'h0000, 1);
        chk_pad(3, "idle_out3");
        chk_read(8'h33, "idle_status");

        // mixed direction port
        ext_val[5] = 8'h3C;
        bus_write(8'h05, 16'h005C, 1);
        bus_write(8'h15, 16'h000F, 1);
        chk_pad(5, "port5_mixed");
        repeat (3) @(posedge clk);
        chk_read(8'h25, "in5_mixed");

        // randomized rounds
        for (int r = 0; r < 8; r++) begin
            int p;
            bus_write(8'h30, 16'h0000, 1);
            for (int i = 0; i < 10; i++) ext_val[i] = 8'($urandom);
            for (int j = 0; j < 3; j++) begin
                p = $urandom_range(0, 9);
                bus_write(8'h00 + 8'(p), 16'($urandom), $urandom_range(1, 3));
                bus_write(8'h10 + 8'(p), 16'($urandom), 1);
            end
            bus_write(8'h32, 16'($urandom), 1);
            bus_write(8'h31, 16'($urandom_range(0, 5)), 1);
            bus_write(8'h30, 16'(1 + 2 * $urandom_range(0, 1)), 1);
            for (int s = 0; s < 12; s++) begin
                repeat ($urandom_range(0, 50)) @(negedge clk);
                p = $urandom_range(0, 9);
                chk_pad(p, $sformatf("rnd%0d_pad%0d", r, p));
                chk_read(8'h33, $sformatf("rnd%0d_status", r));
                if (!(m_mask[p] && m_dir[p] != 8'h00))
                    chk_read(8'h20 + 8'(p), $sformatf("rnd%0d_in%0d", r, p));
                if (s == 6 && $urandom_range(0, 1) == 1)
                    bus_write(8'h30, {14'd0, m_ctrl}, 1);
            end
            bus_write(8'h30, 16'h0000, 1);
            repeat (3) @(posedge clk);
            for (int i = 0; i < 10; i++) chk_read(8'h20 + 8'(i), $sformatf("rnd%0d_idle_in%0d", r, i));
        end

        // reset mid-run aborts immediately
        bus_write(8'h13, 16'h00FF, 1);
        bus_write(8'h32, 16'h0008, 1);
        bus_write(8'h30, 16'h0001, 1);
        repeat (30) @(posedge clk);
        chk_pad(3, "run_before_reset");
        @(posedge clk); #1;
        reset_n = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) ext_val[i] = 8'($urandom);
        pidx = 3; pchk = 1'b1;
        exp_q.push_back({8'h00, m_pad(3)});
        nm_q.push_back("reset_abort_port3");
        @(negedge clk); #1;
        pchk = 1'b0;
        for (int i = 0; i < 10; i++) chk_pad(i, $sformatf("in_reset_pad%0d", i));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        for (int a = 0; a <= 8'h33; a++) chk_read(8'(a), $sformatf("post_reset_rd_%02h", a));

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
